// File: rtl/audio_i2s_tx_if.sv
// Sample-pair handoff from the mixer into the I2S output stage.
interface audio_i2s_tx_if #(
    parameter int IN_BITS = 12
);
    logic                      s_valid;
    logic signed [IN_BITS-1:0] s_left;
    logic signed [IN_BITS-1:0] s_right;

    modport master (output s_valid, s_left, s_right);
    modport slave  (input  s_valid, s_left, s_right);
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S / left-justified serializer with BCLK/LRCLK generation and per-frame strobe.
// A captured pair goes out at the next frame load; no backpressure, late/early samples raise underrun/overflow.
module audio_i2s_tx #(
    parameter int IN_BITS   = 12,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4,
    parameter int FORMAT    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    audio_i2s_tx_if.slave        smp,
    input  logic                 clr_flags,
    output logic                 frame_strobe,
    output logic                 i2s_bclk,
    output logic                 i2s_lrclk,
    output logic                 i2s_sdata,
    output logic                 overflow,
    output logic                 underrun
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PAD        = SLOT_BITS - IN_BITS;

    logic [DIV_W-1:0]      div_cnt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      k;
    logic [FRAME_BITS-1:0] shift;
    logic [FRAME_BITS-1:0] frame_word;
    logic [SLOT_BITS-1:0]  slot_l;
    logic [SLOT_BITS-1:0]  slot_r;
    logic [IN_BITS-1:0]    hold_l;
    logic [IN_BITS-1:0]    hold_r;
    logic                  pending;
    logic                  div_term;
    logic                  fall;
    logic                  load;
    logic                  lr_next;
    logic                  sdata_next;

    // Samples sit verbatim at the top of each slot; pad bits stay zero.
    assign slot_l     = SLOT_BITS'(hold_l) << PAD;
    assign slot_r     = SLOT_BITS'(hold_r) << PAD;
    assign frame_word = {slot_l, slot_r};

    assign div_term = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign fall     = div_term && i2s_bclk;
    assign load     = fall && (k == '0);

    always_comb begin
        k = (bit_cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
        if (FORMAT == 1)
            lr_next = (k >= CNT_W'(SLOT_BITS));
        else
            // I2S: word select flips one BCLK ahead of the slot's MSB.
            lr_next = (k >= CNT_W'(SLOT_BITS - 1)) && (k != CNT_W'(FRAME_BITS - 1));
        if (k == '0)
            sdata_next = frame_word[FRAME_BITS-1];
        else
            sdata_next = shift[CNT_W'(FRAME_BITS - 1) - k];
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt      <= '0;
            i2s_bclk     <= 1'b0;
            i2s_lrclk    <= 1'b0;
            i2s_sdata    <= 1'b0;
            frame_strobe <= 1'b0;
            bit_cnt      <= CNT_W'(FRAME_BITS - 1);
            shift        <= '0;
        end else begin
            frame_strobe <= 1'b0;
            if (div_term) begin
                div_cnt  <= '0;
                i2s_bclk <= ~i2s_bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall) begin
                bit_cnt      <= k;
                i2s_lrclk    <= lr_next;
                i2s_sdata    <= sdata_next;
                frame_strobe <= load;
                if (load)
                    shift <= frame_word;
            end
        end
    end

    // Holding registers and flags survive en=0; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_l   <= '0;
            hold_r   <= '0;
            pending  <= 1'b0;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else if (!en) begin
            pending <= 1'b0;
        end else begin
            if (smp.s_valid) begin
                hold_l  <= smp.s_left;
                hold_r  <= smp.s_right;
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
            if (smp.s_valid && pending && !load)
                overflow <= 1'b1;
            else if (clr_flags)
                overflow <= 1'b0;
            if (load && !pending)
                underrun <= 1'b1;
            else if (clr_flags)
                underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: left-justified and I2S instances share one stimulus stream.
module tb_audio_i2s_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic clr_flags = 1'b0;
    logic s_valid = 1'b0;
    logic signed [11:0] s_left = '0;
    logic signed [11:0] s_right = '0;

    logic f1_fs, f1_bclk, f1_lrclk, f1_sdata, f1_ovf, f1_und;
    logic f0_fs, f0_bclk, f0_lrclk, f0_sdata, f0_ovf, f0_und;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    audio_i2s_tx_if #(.IN_BITS(12)) if_f1 ();
    audio_i2s_tx_if #(.IN_BITS(12)) if_f0 ();
    assign if_f1.s_valid = s_valid;
    assign if_f1.s_left  = s_left;
    assign if_f1.s_right = s_right;
    assign if_f0.s_valid = s_valid;
    assign if_f0.s_left  = s_left;
    assign if_f0.s_right = s_right;

    audio_i2s_tx #(.IN_BITS(12), .SLOT_BITS(16), .BCLK_DIV(2), .FORMAT(1)) dut_lj (
        .clk(clk), .rst(rst), .en(en), .smp(if_f1.slave), .clr_flags(clr_flags),
        .frame_strobe(f1_fs), .i2s_bclk(f1_bclk), .i2s_lrclk(f1_lrclk),
        .i2s_sdata(f1_sdata), .overflow(f1_ovf), .underrun(f1_und)
    );

    audio_i2s_tx #(.IN_BITS(12), .SLOT_BITS(16), .BCLK_DIV(2), .FORMAT(0)) dut_i2s (
        .clk(clk), .rst(rst), .en(en), .smp(if_f0.slave), .clr_flags(clr_flags),
        .frame_strobe(f0_fs), .i2s_bclk(f0_bclk), .i2s_lrclk(f0_lrclk),
        .i2s_sdata(f0_sdata), .overflow(f0_ovf), .underrun(f0_und)
    );

    // Clock edges since the last rst/en release; edge 1 is the first running cycle.
    always @(posedge clk) begin
        if (rst || !en) edge_n <= 0;
        else            edge_n <= edge_n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic at_edge(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic pulse_smp(input int e, input logic [11:0] l, input logic [11:0] r);
        at_edge(e - 1);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        at_edge(e);
        s_valid = 1'b0;
    endtask

    task automatic pulse_clr(input int e);
        at_edge(e - 1);
        clr_flags = 1'b1;
        at_edge(e);
        clr_flags = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic ovf, input logic und);
        chk({tag, "_ovf_lj"}, f1_ovf, ovf);
        chk({tag, "_und_lj"}, f1_und, und);
        chk({tag, "_ovf_i2s"}, f0_ovf, ovf);
        chk({tag, "_und_i2s"}, f0_und, und);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_bclk"}, {f1_bclk, f0_bclk}, 2'b00);
        chk({tag, "_lrclk"}, {f1_lrclk, f0_lrclk}, 2'b00);
        chk({tag, "_sdata"}, {f1_sdata, f0_sdata}, 2'b00);
        chk({tag, "_fs"}, {f1_fs, f0_fs}, 2'b00);
    endtask

    // Monitor: assemble each full frame from the bits present at BCLK falls.
    initial begin
        logic [31:0] sd1, sd0, lr1, lr0, exp;
        int nbits;
        logic bclk_prev;
        nbits = 0;
        bclk_prev = 1'b0;
        sd1 = '0; sd0 = '0; lr1 = '0; lr0 = '0;
        forever begin
            @(negedge clk);
            if (bclk_prev && !f1_bclk) begin
                if (f1_fs) nbits = 0;
                sd1 = {sd1[30:0], f1_sdata};
                sd0 = {sd0[30:0], f0_sdata};
                lr1 = {lr1[30:0], f1_lrclk};
                lr0 = {lr0[30:0], f0_lrclk};
                nbits++;
                if (nbits == 32) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL frame_unexpected actual=%h expected=none", sd1);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("frame_sdata_lj", sd1, exp);
                        chk("frame_sdata_i2s", sd0, exp);
                        chk("frame_lrclk_lj", lr1, 32'h0000_FFFF);
                        chk("frame_lrclk_i2s", lr0, 32'h0001_FFFE);
                    end
                    nbits = 0;
                end
            end
            bclk_prev = f1_bclk;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk_flags("reset", 1'b0, 1'b0);

        exp_q.push_back(32'h0000_0000);
        rst = 1'b0;
        at_edge(3);
        chk("edge3_bclk", f1_bclk, 1'b1);
        chk("edge3_fs", f1_fs, 1'b0);
        at_edge(4);
        chk("edge4_bclk", f1_bclk, 1'b0);
        chk("edge4_fs", {f1_fs, f0_fs}, 2'b11);
        at_edge(5);
        chk("edge5_fs", f1_fs, 1'b0);

        pulse_smp(60, 12'h801, 12'h7FF);
        exp_q.push_back(32'h8010_7FF0);
        at_edge(100);
        chk_flags("first_underrun", 1'b0, 1'b1);
        at_edge(132);
        chk("frame_period_fs", f1_fs, 1'b1);

        pulse_smp(150, 12'h123, 12'h456);
        pulse_smp(200, 12'hABC, 12'hDEF);
        exp_q.push_back(32'hABC0_DEF0);
        at_edge(201);
        chk_flags("overwrite", 1'b1, 1'b1);
        pulse_clr(240);
        at_edge(241);
        chk_flags("clear", 1'b0, 1'b0);

        pulse_smp(300, 12'h111, 12'h222);
        exp_q.push_back(32'h1110_2220);
        // Strobe in the load cycle of frame 3: frame 3 keeps C, D follows.
        pulse_smp(388, 12'h333, 12'h444);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h3330_4440);
        at_edge(400);
        chk_flags("load_cycle_strobe", 1'b0, 1'b0);
        at_edge(600);
        chk_flags("fresh_frame", 1'b0, 1'b0);
        at_edge(645);
        chk_flags("repeat_underrun", 1'b0, 1'b1);
        pulse_clr(700);
        at_edge(701);
        chk_flags("underrun_clr", 1'b0, 1'b0);
        pulse_clr(772);
        chk_flags("set_beats_clr", 1'b0, 1'b1);

        at_edge(1110);
        en = 1'b0;
        @(negedge clk);
        chk_idle("en_off");
        chk_flags("en_off_keep", 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        exp_q.push_back(32'h3330_4440);
        en = 1'b1;
        at_edge(3);
        chk("en_edge3_fs", f1_fs, 1'b0);
        at_edge(4);
        chk("en_edge4_fs", {f1_fs, f0_fs}, 2'b11);

        pulse_smp(50, 12'h0AA, 12'h055);
        pulse_smp(60, 12'hF00, 12'h00F);
        at_edge(61);
        chk_flags("pre_reset", 1'b1, 1'b1);
        at_edge(214);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_mid");
        chk_flags("rst_mid", 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        exp_q.push_back(32'h0000_0000);
        rst = 1'b0;
        at_edge(4);
        chk("rst_edge4_fs", f1_fs, 1'b1);
        at_edge(130);
        chk_flags("post_reset", 1'b0, 1'b1);
        chk("frames_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
